// File: rtl/stopwatch_core.sv
// BCD MM:SS stopwatch fed by slow divider clocks, with a multiplexed 7-segment display.
// Optional macro STOPWATCH_BLINK_EN blanks the field being adjusted while clk_five is high.
module stopwatch_core #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SEC_WRAP    = 59,
  parameter int unsigned MIN_WRAP    = 99
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       clk_one,
  input  logic       clk_five,
  input  logic       clk_m,
  input  logic       pause_i,
  input  logic       clear_i,
  input  logic       adj_i,
  input  logic       sel_i,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic       running_o,
  output logic [3:0] an_o,
  output logic [6:0] seg_o
);

  localparam int unsigned N_SLOW = 3;
  localparam int unsigned MSB    = SYNC_STAGES - 1;
  localparam logic [7:0] SEC_WRAP_BCD = {4'(SEC_WRAP / 10), 4'(SEC_WRAP % 10)};
  localparam logic [7:0] MIN_WRAP_BCD = {4'(MIN_WRAP / 10), 4'(MIN_WRAP % 10)};
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  // Index 0 = clk_one, 1 = clk_five, 2 = clk_m
  logic [N_SLOW-1:0]                  slow;
  logic [N_SLOW-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [N_SLOW-1:0]                  dly_q, dly_d;
  logic [N_SLOW-1:0]                  tick;
  logic one_tick, five_tick, m_tick;

  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       running_q, running_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic [3:0] digit;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] wrap);
    if (v == wrap)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign slow = {clk_m, clk_five, clk_one};

  // Shift each slow clock in at bit 0; the MSB is the settled level
  always_comb begin
    sync_d = sync_q;
    dly_d  = dly_q;
    tick   = '0;
    for (int i = 0; i < int'(N_SLOW); i++) begin
      if (SYNC_STAGES > 1) sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], slow[i]};
      else                 sync_d[i][0] = slow[i];
      dly_d[i] = sync_q[i][MSB];
      tick[i]  = sync_q[i][MSB] & ~dly_q[i];
    end
  end

  assign one_tick  = tick[0];
  assign five_tick = tick[1];
  assign m_tick    = tick[2];

  // Time update: clear beats adjust beats normal counting
  always_comb begin
    min_d     = min_q;
    sec_d     = sec_q;
    running_d = running_q ^ pause_i;
    if (clear_i) begin
      min_d = 8'h00;
      sec_d = 8'h00;
    end else if (adj_i) begin
      if (five_tick) begin
        if (sel_i) sec_d = bcd_inc(sec_q, SEC_WRAP_BCD);
        else       min_d = bcd_inc(min_q, MIN_WRAP_BCD);
      end
    end else if (running_q && one_tick) begin
      sec_d = bcd_inc(sec_q, SEC_WRAP_BCD);
      if (sec_q == SEC_WRAP_BCD) min_d = bcd_inc(min_q, MIN_WRAP_BCD);
    end
  end

  // Display is decoded from next-state values so digits and anodes move together
  always_comb begin
    idx_d = idx_q + 2'(m_tick);
    an_d  = 4'b1111;
    digit = 4'd0;
    case (idx_d)
      2'd0: begin an_d = 4'b1110; digit = sec_d[3:0]; end
      2'd1: begin an_d = 4'b1101; digit = sec_d[7:4]; end
      2'd2: begin an_d = 4'b1011; digit = min_d[3:0]; end
      default: begin an_d = 4'b0111; digit = min_d[7:4]; end
    endcase
`ifdef STOPWATCH_BLINK_EN
    if (adj_i && sync_q[1][MSB] && (sel_i != idx_d[1])) an_d = 4'b1111;
`endif
    seg_d = seg_decode(digit);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      dly_q     <= '0;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      running_q <= 1'b1;
      idx_q     <= 2'd0;
      an_q      <= 4'b1110;
      seg_q     <= SEG_ZERO;
    end else begin
      sync_q    <= sync_d;
      dly_q     <= dly_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      running_q <= running_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign min_o     = min_q;
  assign sec_o     = sec_q;
  assign running_o = running_q;
  assign an_o      = an_q;
  assign seg_o     = seg_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: stimulus pushes expected state changes with
// their expected cycle; negedge monitors pop and compare whenever the outputs change.
module tb_stopwatch_core;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;

  logic       clk_i, rst_n;
  logic       clk_one, clk_five, clk_m;
  logic       pause_i, clear_i, adj_i, sel_i;
  logic [7:0] min_o, sec_o;
  logic       running_o;
  logic [3:0] an_o;
  logic [6:0] seg_o;

  stopwatch_core #(.SYNC_STAGES(SYNC), .SEC_WRAP(59), .MIN_WRAP(99)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .clk_one(clk_one), .clk_five(clk_five), .clk_m(clk_m),
    .pause_i(pause_i), .clear_i(clear_i), .adj_i(adj_i), .sel_i(sel_i),
    .min_o(min_o), .sec_o(sec_o), .running_o(running_o), .an_o(an_o), .seg_o(seg_o)
  );

  typedef struct {logic [7:0] m; logic [7:0] s; logic r; int cyc;} st_t;
  typedef struct {logic [3:0] an; logic [6:0] seg; int cyc;} ds_t;

  st_t st_q[$];
  ds_t ds_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  bit  mon_en   = 0;
  bit  disp_en  = 0;

  logic [7:0] m_exp = 8'h00, s_exp = 8'h00;
  logic       r_exp = 1'b1;
  int         idx_exp = 0;
  bit         five_hi = 0;
  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic int b2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] i2b(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] inc(input logic [7:0] b, input int wrap);
    int v;
    v = b2i(b);
    return i2b((v == wrap) ? 0 : v + 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_st(input int at);
    st_t e;
    e.m = m_exp; e.s = s_exp; e.r = r_exp; e.cyc = at;
    st_q.push_back(e);
  endtask

  // State monitor
  logic [16:0] st_prev = 17'h00001;
  always @(negedge clk_i) begin
    logic [16:0] cur;
    st_t e;
    cur = {min_o, sec_o, running_o};
    if (mon_en && cur !== st_prev) begin
      n_checks++;
      if (st_q.size() == 0) begin
        n_fail++;
        $display("FAIL state_unexpected: got %h:%h run=%b at cyc %0d, nothing expected",
                 min_o, sec_o, running_o, cyc);
      end else begin
        e = st_q.pop_front();
        if (min_o !== e.m || sec_o !== e.s || running_o !== e.r || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL state: got %h:%h run=%b cyc %0d expected %h:%h run=%b cyc %0d",
                   min_o, sec_o, running_o, cyc, e.m, e.s, e.r, e.cyc);
        end
      end
    end
    st_prev = cur;
  end

  // Display monitor
  logic [10:0] ds_prev = '0;
  always @(negedge clk_i) begin
    logic [10:0] cur;
    ds_t e;
    cur = {an_o, seg_o};
    if (disp_en && cur !== ds_prev) begin
      n_checks++;
      if (ds_q.size() == 0) begin
        n_fail++;
        $display("FAIL disp_unexpected: got an=%b seg=%b at cyc %0d", an_o, seg_o, cyc);
      end else begin
        e = ds_q.pop_front();
        if (an_o !== e.an || seg_o !== e.seg || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL disp: got an=%b seg=%b cyc %0d expected an=%b seg=%b cyc %0d",
                   an_o, seg_o, cyc, e.an, e.seg, e.cyc);
        end
      end
    end
    ds_prev = cur;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic one_edge();
    @(posedge clk_i); #1;
    clk_one = 1'b1;
    if (!adj_i && r_exp) begin
      if (s_exp == 8'h59) m_exp = inc(m_exp, 99);
      s_exp = inc(s_exp, 59);
      push_st(cyc + LAT);
    end
    cycles(4);
    clk_one = 1'b0;
    cycles(4);
  endtask

  task automatic five_edge();
    @(posedge clk_i); #1;
    clk_five = 1'b1;
    if (adj_i) begin
      if (sel_i) s_exp = inc(s_exp, 59);
      else       m_exp = inc(m_exp, 99);
      push_st(cyc + LAT);
    end
    cycles(4);
    clk_five = 1'b0;
    cycles(4);
  endtask

  task automatic m_edge();
    ds_t e;
    int  d;
    @(posedge clk_i); #1;
    clk_m = 1'b1;
    idx_exp = (idx_exp + 1) % 4;
    case (idx_exp)
      0: begin e.an = 4'b1110; d = int'(s_exp[3:0]); end
      1: begin e.an = 4'b1101; d = int'(s_exp[7:4]); end
      2: begin e.an = 4'b1011; d = int'(m_exp[3:0]); end
      default: begin e.an = 4'b0111; d = int'(m_exp[7:4]); end
    endcase
`ifdef STOPWATCH_BLINK_EN
    if (adj_i && five_hi && (sel_i == (idx_exp < 2))) e.an = 4'b1111;
`endif
    e.seg = seg_tab[d];
    e.cyc = cyc + LAT;
    ds_q.push_back(e);
    cycles(4);
    clk_m = 1'b0;
    cycles(4);
  endtask

  task automatic pause_pulse();
    @(posedge clk_i); #1;
    pause_i = 1'b1;
    r_exp = ~r_exp;
    push_st(cyc + 1);
    @(posedge clk_i); #1;
    pause_i = 1'b0;
    cycles(2);
  endtask

  task automatic set_field(input logic sel, input logic [7:0] target);
    adj_i = 1'b1;
    sel_i = sel;
    cycles(2);
    for (int k = 0; k < 100; k++) begin
      if ((sel ? s_exp : m_exp) == target) break;
      five_edge();
    end
    adj_i = 1'b0;
    cycles(2);
  endtask

  initial begin
    rst_n = 1'b0; clk_one = 0; clk_five = 0; clk_m = 0;
    pause_i = 0; clear_i = 0; adj_i = 0; sel_i = 0;
    cycles(3);
    chk("reset_min", 32'(min_o), 32'h00);
    chk("reset_sec", 32'(sec_o), 32'h00);
    chk("reset_run", 32'(running_o), 32'h1);
    chk("reset_an", 32'(an_o), 32'b1110);
    chk("reset_seg", 32'(seg_o), 32'b1000000);
    rst_n = 1'b1;
    cycles(3);
    mon_en = 1;

    // Plain counting 00 -> 03
    repeat (3) one_edge();

    // Seconds carry into minutes, then full wrap 99:59 -> 00:00
    set_field(1'b1, 8'h59);
    one_edge();
    set_field(1'b0, 8'h99);
    set_field(1'b1, 8'h59);
    one_edge();

    // Pause freezes counting; resume continues on the next tick
    pause_pulse();
    repeat (5) one_edge();
    pause_pulse();
    one_edge();

    // Adjust seconds across the wrap, count clock ignored while adjusting
    set_field(1'b1, 8'h58);
    adj_i = 1'b1; sel_i = 1'b1;
    cycles(2);
    repeat (3) begin
      five_edge();
      one_edge();
    end
    adj_i = 1'b0;
    cycles(2);

    // Preload 12:34 and scan the display twice
    set_field(1'b0, 8'h12);
    set_field(1'b1, 8'h34);
    disp_en = 1;
    repeat (8) m_edge();

`ifdef STOPWATCH_BLINK_EN
    adj_i = 1'b1; sel_i = 1'b0;
    cycles(2);
    @(posedge clk_i); #1;
    clk_five = 1'b1;
    m_exp = inc(m_exp, 99);
    push_st(cyc + LAT);
    cycles(4);
    five_hi = 1;
    repeat (4) m_edge();
    clk_five = 1'b0;
    cycles(4);
    five_hi = 0;
    adj_i = 1'b0;
    cycles(2);
`endif
    disp_en = 0;
    cycles(2);

    // Clear coincident with a count tick: tick discarded, run flag kept
    @(posedge clk_i); #1;
    clk_one = 1'b1;
    cycles(2);
    clear_i = 1'b1;
    m_exp = 8'h00; s_exp = 8'h00;
    push_st(cyc + 1);
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    cycles(3);
    clk_one = 1'b0;
    cycles(4);

    one_edge();
    chk("queue_state_empty", 32'(st_q.size()), 32'd0);
    chk("queue_disp_empty", 32'(ds_q.size()), 32'd0);

    // Asynchronous reset in the middle of a pending tick
    @(posedge clk_i); #1;
    clk_one = 1'b1;
    cycles(1);
    #2;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("async_min", 32'(min_o), 32'h00);
    chk("async_sec", 32'(sec_o), 32'h00);
    chk("async_run", 32'(running_o), 32'h1);
    chk("async_an", 32'(an_o), 32'b1110);
    chk("async_seg", 32'(seg_o), 32'b1000000);
    clk_one = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(6);
    chk("post_reset_sec", 32'(sec_o), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Consumer end of the clock-divider outputs: clk_one, clk_five and clk_m arrive as slow square waves generated from clk_i.
- The block synchronises them into clk_i and edge-detects them into single-cycle ticks.
- It keeps a BCD MM:SS stopwatch with run/pause, clear and adjust modes.
- It time-multiplexes the four digits onto an active-low 7-segment display.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per incoming slow clock; legal range is 2 or more.
- SEC_WRAP, 59, last seconds value before wrapping to 00.
- MIN_WRAP, 99, last minutes value before wrapping to 00.

Ports:
- clk_i  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clk_one  in  1  count clock square wave from the divider.
- clk_five  in  1  adjust/blink clock square wave from the divider.
- clk_m  in  1  display refresh square wave from the divider.
- pause_i  in  1  single-cycle pulse (debounced upstream); toggles run/pause.
- clear_i  in  1  single-cycle pulse; zeroes the time.
- adj_i  in  1  level; 1 selects adjust mode.
- sel_i  in  1  adjust field select: 0 = minutes, 1 = seconds.
- min_o  out  8  minutes as BCD, {tens, ones}.
- sec_o  out  8  seconds as BCD, {tens, ones}.
- running_o  out  1  run flag.
- an_o  out  4  digit anodes, active-low.
- seg_o  out  7  segments, active-low; bit0 = a … bit6 = g.

Behaviour:
- Reset (async assert, sync release):
  - min_o = 8'h00, sec_o = 8'h00, running_o = 1.
  - Digit index = 0, so an_o = 4'b1110 and seg_o shows "0" (7'b1000000).
  - All synchroniser and edge flops cleared.
- Tick generation, per slow clock:
  - SYNC_STAGES-flop synchroniser, then a delay flop.
  - tick = last sync stage AND NOT delay flop: one clk_i cycle per rising edge of the slow clock; falling edges produce nothing.
  - A counter/display register reacts at the (SYNC_STAGES+1)th clk_i edge after the slow clock is first sampled high (3 edges at the default).
- Mode priority, evaluated each cycle, highest first:
  1. clear_i:
     - min/sec forced to 00:00.
     - running unchanged.
     - Any coincident one_tick or five_tick is discarded.
  2. adj_i = 1:
     - one_tick is ignored.
     - On five_tick the selected field increments by 1 in BCD.
     - Seconds wrap SEC_WRAP→00 and minutes wrap MIN_WRAP→00; no carry between fields.
  3. adj_i = 0 and running = 1:
     - On one_tick, seconds increment.
     - At SEC_WRAP, seconds go to 00 and minutes increment in the same cycle.
     - 99:59 → 00:00.
  4. Otherwise the time holds.
- pause_i toggles running in any mode, including adjust and during clear.
  - The toggle takes effect from the next cycle.
  - Leaving adjust resumes counting per the current running flag.
- BCD rules:
  - The ones digit wraps 9→0 and carries into tens.
  - Values never leave legal BCD; no illegal code is reachable from reset.
- Display:
  - A 2-bit digit index advances 0→1→2→3→0 on each m_tick.
  - idx0: an_o = 1110, sec ones.
  - idx1: an_o = 1101, sec tens.
  - idx2: an_o = 1011, min ones.
  - idx3: an_o = 0111, min tens.
  - seg_o is decoded from the digit shown, using the standard active-low 0–9 patterns; an_o and seg_o change in the same cycle.
- Outputs are registered; min_o/sec_o/running_o update on the edge where the triggering tick/pulse is high.

Optional Feature:
- Macro: STOPWATCH_BLINK_EN.
- Defined:
  - While adj_i = 1 and the synchronised clk_five level is 1, the two digits of the selected field are blanked: an_o = 4'b1111 when the index points at them.
  - The other field displays normally.
- Undefined:
  - No blanking; adjust mode is visible only through value changes.
  - The synchronised clk_five level is not used for display.

Test Plan:
- Reset release, 3 clk_one rising edges, adj_i = 0 → sec_o 00→01→02→03, each change 3 clk_i edges after clk_one sampled high; min_o = 00.
- Preload 00:59 via adjust, run one clk_one edge → 01:00. Preload 99:59, one tick → 00:00.
- pause_i pulse, then 5 clk_one edges → time frozen, running_o = 0. Second pause_i → counting resumes on the next tick.
- adj_i = 1, sel_i = 1, sec 58, 3 clk_five edges → 59, 00, 01 with min unchanged; clk_one edges ignored throughout.
- clear_i asserted in the same cycle as a one_tick at 12:34 → 00:00 and running_o unchanged. rst_n asserted mid-count → all outputs at their reset values immediately (async).
- 8 clk_m edges at 12:34 → an_o cycles 1110, 1101, 1011, 0111 twice with seg_o = 4, 3, 2, 1. With STOPWATCH_BLINK_EN, adj_i = 1, sel_i = 0, clk_five high → an_o = 1111 at idx2/idx3.
